ex_operand_stage: RTL and testbench

- Decode-to-execute pipeline register that directly feeds the 16-bit ALU in the execute stage.
- Captures decoded operands and ALU control on each advancing cycle: Op, invA, invB, Cin, sign.
- Selects B from register or sign-extended immediate.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Supports stall (hold) and flush (bubble insertion) from hazard/branch logic.

---
 rtl/ex_operand_stage_pkg.sv | 29 ++
 rtl/ex_operand_stage_fwd_mux.sv | 31 +++
 rtl/ex_operand_stage.sv | 149 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - shared widths, ALU op codes and forwarding encodings
package ex_operand_stage_pkg;

  localparam int DATA_W = 16;
  localparam int IDX_W  = 3;
  localparam int IMM_W  = 8;

  // ALU op codes; 000 is the shift op a bubble decays to
  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  // operand source reported on ex_fwd_a / ex_fwd_b
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_t;

  function automatic logic [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// rtl/ex_operand_stage_fwd_mux.sv - single-operand priority forwarding selector
import ex_operand_stage_pkg::*;

module fwd_mux (
  input  logic              en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exm_wr_en,
  input  logic [IDX_W-1:0]  exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_wr_en,
  input  logic [IDX_W-1:0]  mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] data,
  output fwd_sel_t          sel
);

  // youngest producer wins: EX/MEM before MEM/WB before the register file value
  always_comb begin
    data = reg_data;
    sel  = FWD_REG;
    if (en && exm_wr_en && (exm_rd == idx)) begin
      data = exm_data;
      sel  = FWD_EXM;
    end else if (en && mwb_wr_en && (mwb_rd == idx)) begin
      data = mwb_data;
      sel  = FWD_MWB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - decode-to-execute operand register with forwarding (EX_FWD_EN enables forwarding)
import ex_operand_stage_pkg::*;

module ex_operand_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [IDX_W-1:0]  id_rs_idx,
  input  logic [IDX_W-1:0]  id_rt_idx,
  input  logic [IDX_W-1:0]  id_rd_idx,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_use_imm,
  input  logic [2:0]        id_alu_op,
  input  logic              id_inv_a,
  input  logic              id_inv_b,
  input  logic              id_cin,
  input  logic              id_sign,
  input  logic              id_reg_write,
  input  logic              exm_wr_en,
  input  logic [IDX_W-1:0]  exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_wr_en,
  input  logic [IDX_W-1:0]  mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        ex_alu_op,
  output logic              ex_inv_a,
  output logic              ex_inv_b,
  output logic              ex_cin,
  output logic              ex_sign,
  output logic [IDX_W-1:0]  ex_rd_idx,
  output logic              ex_reg_write,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b
);

`ifdef EX_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic              valid_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [IDX_W-1:0]  rs_idx_q;
  logic [IDX_W-1:0]  rt_idx_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [DATA_W-1:0] imm_ext_q;
  logic              use_imm_q;
  logic [2:0]        alu_op_q;
  logic              inv_a_q;
  logic              inv_b_q;
  logic              cin_q;
  logic              sign_q;
  logic              reg_write_q;

  // reset/flush load a bubble, stall holds (refreshing from write-back), otherwise capture decode
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      rs_idx_q    <= '0;
      rt_idx_q    <= '0;
      rd_idx_q    <= '0;
      imm_ext_q   <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= OP_ROL;
      inv_a_q     <= 1'b0;
      inv_b_q     <= 1'b0;
      cin_q       <= 1'b0;
      sign_q      <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (stall) begin
      // a write-back retiring during the stall would otherwise be missed by the held operands
      if (mwb_wr_en && (mwb_rd == rs_idx_q)) rs_data_q <= mwb_data;
      if (mwb_wr_en && (mwb_rd == rt_idx_q)) rt_data_q <= mwb_data;
    end else begin
      valid_q     <= id_valid;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      rs_idx_q    <= id_rs_idx;
      rt_idx_q    <= id_rt_idx;
      rd_idx_q    <= id_rd_idx;
      imm_ext_q   <= sign_ext(id_imm);
      use_imm_q   <= id_use_imm;
      alu_op_q    <= id_alu_op;
      inv_a_q     <= id_inv_a;
      inv_b_q     <= id_inv_b;
      cin_q       <= id_cin;
      sign_q      <= id_sign;
      reg_write_q <= id_reg_write;
    end
  end

  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  fwd_sel_t          a_sel;
  fwd_sel_t          b_sel;

  fwd_mux u_fwd_a (
    .en        (valid_q & FWD_ON),
    .idx       (rs_idx_q),
    .reg_data  (rs_data_q),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .exm_data  (exm_data),
    .mwb_wr_en (mwb_wr_en),
    .mwb_rd    (mwb_rd),
    .mwb_data  (mwb_data),
    .data      (a_data),
    .sel       (a_sel)
  );

  fwd_mux u_fwd_b (
    .en        (valid_q & ~use_imm_q & FWD_ON),
    .idx       (rt_idx_q),
    .reg_data  (rt_data_q),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .exm_data  (exm_data),
    .mwb_wr_en (mwb_wr_en),
    .mwb_rd    (mwb_rd),
    .mwb_data  (mwb_data),
    .data      (b_data),
    .sel       (b_sel)
  );

  assign ex_valid     = valid_q;
  assign ex_a         = a_data;
  assign ex_b         = use_imm_q ? imm_ext_q : b_data;
  assign ex_alu_op    = alu_op_q;
  assign ex_inv_a     = inv_a_q;
  assign ex_inv_b     = inv_b_q;
  assign ex_cin       = cin_q;
  assign ex_sign      = sign_q;
  assign ex_rd_idx    = rd_idx_q;
  assign ex_reg_write = reg_write_q & valid_q;
  assign ex_fwd_a     = a_sel;
  assign ex_fwd_b     = b_sel;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage (honours EX_FWD_EN)
module tb_ex_operand_stage;

`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [15:0] id_rs_data, id_rt_data;
  logic [2:0]  id_rs_idx, id_rt_idx, id_rd_idx;
  logic [7:0]  id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_op;
  logic        id_inv_a, id_inv_b, id_cin, id_sign, id_reg_write;
  logic        exm_wr_en;
  logic [2:0]  exm_rd;
  logic [15:0] exm_data;
  logic        mwb_wr_en;
  logic [2:0]  mwb_rd;
  logic [15:0] mwb_data;
  logic        ex_valid;
  logic [15:0] ex_a, ex_b;
  logic [2:0]  ex_alu_op;
  logic        ex_inv_a, ex_inv_b, ex_cin, ex_sign;
  logic [2:0]  ex_rd_idx;
  logic        ex_reg_write;
  logic [1:0]  ex_fwd_a, ex_fwd_b;

  int n_chk  = 0;
  int n_fail = 0;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_inv_a(id_inv_a), .id_inv_b(id_inv_b), .id_cin(id_cin), .id_sign(id_sign),
    .id_reg_write(id_reg_write),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op),
    .ex_inv_a(ex_inv_a), .ex_inv_b(ex_inv_b), .ex_cin(ex_cin), .ex_sign(ex_sign),
    .ex_rd_idx(ex_rd_idx), .ex_reg_write(ex_reg_write),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; flush = 1'b0; id_valid = 1'b1;
    id_rs_data = 16'h7777; id_rt_data = 16'h8888;
    id_rs_idx = 3'd1; id_rt_idx = 3'd1; id_rd_idx = 3'd1;
    id_imm = 8'h00; id_use_imm = 1'b0; id_alu_op = 3'b101;
    id_inv_a = 1'b1; id_inv_b = 1'b0; id_cin = 1'b0; id_sign = 1'b1; id_reg_write = 1'b1;
    exm_wr_en = 1'b0; exm_rd = 3'd0; exm_data = 16'h0;
    mwb_wr_en = 1'b0; mwb_rd = 3'd0; mwb_data = 16'h0;

    // reset dominates stall with a valid decode slot
    step(); step();
    chk("rst_valid", {15'd0, ex_valid}, 16'd0);
    chk("rst_a", ex_a, 16'h0000);
    chk("rst_alu_op", {13'd0, ex_alu_op}, 16'd0);
    chk("rst_reg_write", {15'd0, ex_reg_write}, 16'd0);

    // advance with negative immediate
    rst = 1'b0; stall = 1'b0;
    id_rs_data = 16'h1234; id_rt_data = 16'h9999;
    id_rs_idx = 3'd1; id_rt_idx = 3'd3; id_rd_idx = 3'd5;
    id_imm = 8'hF0; id_use_imm = 1'b1; id_alu_op = 3'b100;
    id_inv_a = 1'b0; id_inv_b = 1'b1; id_cin = 1'b1; id_sign = 1'b0;
    step();
    chk("adv_valid", {15'd0, ex_valid}, 16'd1);
    chk("adv_a", ex_a, 16'h1234);
    chk("adv_b_imm_neg", ex_b, 16'hFFF0);
    chk("adv_alu_op", {13'd0, ex_alu_op}, 16'd4);
    chk("adv_ctrl", {12'd0, ex_inv_a, ex_inv_b, ex_cin, ex_sign}, 16'b0110);
    chk("adv_rd", {13'd0, ex_rd_idx}, 16'd5);
    chk("adv_reg_write", {15'd0, ex_reg_write}, 16'd1);
    chk("adv_fwd_b_imm", {14'd0, ex_fwd_b}, 16'd0);

    // both producers target r2; EX/MEM must win
    id_rs_data = 16'h1111; id_rt_data = 16'h2222;
    id_rs_idx = 3'd2; id_rt_idx = 3'd2; id_use_imm = 1'b0; id_imm = 8'h05;
    step();
    exm_wr_en = 1'b1; exm_rd = 3'd2; exm_data = 16'hAAAA;
    mwb_wr_en = 1'b1; mwb_rd = 3'd2; mwb_data = 16'h5555;
    #1;
    chk("fwd_exm_a", ex_a, FWD ? 16'hAAAA : 16'h1111);
    chk("fwd_exm_b", ex_b, FWD ? 16'hAAAA : 16'h2222);
    chk("fwd_exm_sel_a", {14'd0, ex_fwd_a}, FWD ? 16'd1 : 16'd0);
    chk("fwd_exm_sel_b", {14'd0, ex_fwd_b}, FWD ? 16'd1 : 16'd0);
    exm_wr_en = 1'b0;
    #1;
    chk("fwd_mwb_a", ex_a, FWD ? 16'h5555 : 16'h1111);
    chk("fwd_mwb_sel_a", {14'd0, ex_fwd_a}, FWD ? 16'd2 : 16'd0);
    mwb_rd = 3'd3;
    #1;
    chk("fwd_none_a", ex_a, 16'h1111);
    chk("fwd_none_sel_a", {14'd0, ex_fwd_a}, 16'd0);

    // positive immediate ignores a matching producer on rt
    mwb_rd = 3'd2; mwb_wr_en = 1'b0;
    id_use_imm = 1'b1; id_imm = 8'h7F;
    step();
    mwb_wr_en = 1'b1;
    #1;
    chk("imm_pos_b", ex_b, 16'h007F);
    chk("imm_skip_fwd_b", {14'd0, ex_fwd_b}, 16'd0);
    mwb_wr_en = 1'b0;

    // stall with a write-back to the held rs retiring mid-stall
    id_use_imm = 1'b0; id_rs_idx = 3'd4; id_rs_data = 16'h0123;
    id_rt_idx = 3'd6; id_rt_data = 16'h4444;
    step();
    stall = 1'b1; id_rs_data = 16'hDEAD; id_rt_data = 16'hBEEF;
    step();
    chk("stall_hold_a", ex_a, 16'h0123);
    mwb_wr_en = 1'b1; mwb_rd = 3'd4; mwb_data = 16'h0BAD;
    step();
    mwb_wr_en = 1'b0; mwb_rd = 3'd0; mwb_data = 16'h0000;
    step();
    chk("stall_refresh_a", ex_a, 16'h0BAD);
    chk("stall_refresh_sel_a", {14'd0, ex_fwd_a}, 16'd0);
    chk("stall_hold_b", ex_b, 16'h4444);

    // flush beats stall; bubble must not forward even when rs index 0 matches
    flush = 1'b1; id_valid = 1'b1; id_reg_write = 1'b1;
    step();
    flush = 1'b0;
    exm_wr_en = 1'b1; exm_rd = 3'd0; exm_data = 16'hCAFE;
    #1;
    chk("flush_valid", {15'd0, ex_valid}, 16'd0);
    chk("flush_reg_write", {15'd0, ex_reg_write}, 16'd0);
    chk("flush_fwd", {12'd0, ex_fwd_a, ex_fwd_b}, 16'd0);
    chk("flush_a", ex_a, 16'h0000);
    chk("flush_alu_op", {13'd0, ex_alu_op}, 16'd0);
    exm_wr_en = 1'b0;

    // reset during a stall still clears a valid entry
    stall = 1'b0; id_rs_data = 16'h4321;
    step();
    chk("pre_rst_valid", {15'd0, ex_valid}, 16'd1);
    stall = 1'b1; rst = 1'b1;
    step();
    chk("stall_rst_valid", {15'd0, ex_valid}, 16'd0);
    chk("stall_rst_a", ex_a, 16'h0000);
    rst = 1'b0; stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
